// File: rtl/convertir_bcd_seq.sv
// convertir_bcd_seq
// Sequential binary-to-BCD converter with leading-zero blanking, used on the
// dice display path between the die result register and the 7-segment decoders.
// A value is accepted through a demarrer/pret handshake, converted over LARGEUR
// cycles with the shift-add-3 (double-dabble) algorithm, and then presented as
// registered BCD digits, per-digit display enables and an overflow flag.
//
// Parameters:
//   LARGEUR      width of the binary input (1..32)
//   NB_CHIFFRES  number of BCD digits produced (1..10)
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   valeur       unsigned binary value, sampled on the accept edge only
//   demarrer     conversion request, accepted when demarrer && pret
//   pret         high while idle (REPOS)
//   bcd          registered digits, digit k at bcd[4k+3:4k], k=0 is units
//   en           registered display enables, one per digit
//   depassement  registered overflow flag (value >= 10^NB_CHIFFRES)
//   valide       one-cycle pulse after bcd/en/depassement are updated
module convertir_bcd_seq #(
  parameter int LARGEUR     = 7,
  parameter int NB_CHIFFRES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LARGEUR-1:0]       valeur,
  input  logic                     demarrer,
  output logic                     pret,
  output logic [4*NB_CHIFFRES-1:0] bcd,
  output logic [NB_CHIFFRES-1:0]   en,
  output logic                     depassement,
  output logic                     valide
);

  localparam int W  = 4 * NB_CHIFFRES;
  localparam int CW = 6;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Overflow can only happen when 10^NB_CHIFFRES is reachable by the input
  // width; otherwise the flag is a constant zero.
  localparam logic [63:0] LIMITE       = pow10(NB_CHIFFRES);
  localparam logic [63:0] MAX_VAL      = (64'd1 << LARGEUR) - 64'd1;
  localparam bit          DEP_POSSIBLE = (LIMITE <= MAX_VAL);

  typedef enum logic [1:0] {
    REPOS,
    CONVERSION,
    FIN
  } etat_t;

  etat_t                etat_q, etat_d;
  logic [LARGEUR-1:0]   sr_q, sr_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 dep_int_q, dep_int_d;
  logic [W-1:0]         bcd_q, bcd_d;
  logic [NB_CHIFFRES-1:0] en_q, en_d;
  logic                 dep_q, dep_d;
  logic                 valide_q, valide_d;

  logic [63:0]          valeur_ext;
  logic                 dep_calc;
  logic [W-1:0]         acc_adj;
  logic [W-1:0]         acc_shift;
  logic [NB_CHIFFRES-1:0] en_calc;
  logic                 any_nz;

  always_comb begin
    valeur_ext = 64'(valeur);
    dep_calc   = DEP_POSSIBLE && (valeur_ext >= LIMITE);

    // Add 3 to every digit >= 5 so the following shift carries correctly
    // into the next decimal digit.
    acc_adj = acc_q;
    for (int k = 0; k < NB_CHIFFRES; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    // The accumulator MSB is dropped; that only matters for overflowing
    // values, whose result is replaced by all nines anyway.
    acc_shift = {acc_adj[W-2:0], sr_q[LARGEUR-1]};

    // A digit is shown when it or any more significant digit is non-zero;
    // the units digit is always shown.
    en_calc = '0;
    any_nz  = 1'b0;
    for (int k = NB_CHIFFRES - 1; k >= 0; k--) begin
      any_nz     = any_nz | (|acc_q[4*k +: 4]);
      en_calc[k] = any_nz;
    end
    en_calc[0] = 1'b1;

    etat_d    = etat_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dep_int_d = dep_int_q;
    bcd_d     = bcd_q;
    en_d      = en_q;
    dep_d     = dep_q;
    valide_d  = 1'b0;

    case (etat_q)
      REPOS: begin
        if (demarrer) begin
          sr_d      = valeur;
          acc_d     = '0;
          dep_int_d = dep_calc;
          cnt_d     = CW'(LARGEUR);
          etat_d    = CONVERSION;
        end
      end
      CONVERSION: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          etat_d = FIN;
        end
      end
      FIN: begin
        valide_d = 1'b1;
        if (dep_int_q) begin
          bcd_d = {NB_CHIFFRES{4'h9}};
          en_d  = '1;
          dep_d = 1'b1;
        end else begin
          bcd_d = acc_q;
          en_d  = en_calc;
          dep_d = 1'b0;
        end
        etat_d = REPOS;
      end
      default: begin
        etat_d = REPOS;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      etat_q    <= REPOS;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dep_int_q <= 1'b0;
      bcd_q     <= '0;
      en_q      <= NB_CHIFFRES'(1);
      dep_q     <= 1'b0;
      valide_q  <= 1'b0;
    end else begin
      etat_q    <= etat_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dep_int_q <= dep_int_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      dep_q     <= dep_d;
      valide_q  <= valide_d;
    end
  end

  assign pret        = (etat_q == REPOS);
  assign bcd         = bcd_q;
  assign en          = en_q;
  assign depassement = dep_q;
  assign valide      = valide_q;

endmodule

// File: tb/tb_convertir_bcd_seq.sv
// tb_convertir_bcd_seq
// Self-checking bench for convertir_bcd_seq. Three instances are exercised:
// default (7 bits, 3 digits), a 2-digit one for overflow and a 16-bit/5-digit
// one for the wide case. Directed vectors come from a table; back-to-back
// operation and reset during a conversion are hand-written sequences.
module tb_convertir_bcd_seq;

  logic clk;
  logic rst_n;
  logic dem [3];
  logic [15:0] val_in [3];

  logic        pret_a, pret_b, pret_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
  logic [2:0]  en_a;
  logic [1:0]  en_b;
  logic [4:0]  en_c;
  logic        dep_a, dep_b, dep_c;
  logic        valide_a, valide_b, valide_c;

  logic [19:0] bcd_m [3];
  logic [4:0]  en_m [3];
  logic        dep_m [3];
  logic        valide_m [3];
  logic        pret_m [3];

  int n_cmp;
  int n_fail;

  convertir_bcd_seq #(.LARGEUR(7), .NB_CHIFFRES(3)) u_a (
    .clk(clk), .rst_n(rst_n), .valeur(val_in[0][6:0]), .demarrer(dem[0]),
    .pret(pret_a), .bcd(bcd_a), .en(en_a), .depassement(dep_a), .valide(valide_a)
  );

  convertir_bcd_seq #(.LARGEUR(7), .NB_CHIFFRES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .valeur(val_in[1][6:0]), .demarrer(dem[1]),
    .pret(pret_b), .bcd(bcd_b), .en(en_b), .depassement(dep_b), .valide(valide_b)
  );

  convertir_bcd_seq #(.LARGEUR(16), .NB_CHIFFRES(5)) u_c (
    .clk(clk), .rst_n(rst_n), .valeur(val_in[2]), .demarrer(dem[2]),
    .pret(pret_c), .bcd(bcd_c), .en(en_c), .depassement(dep_c), .valide(valide_c)
  );

  assign bcd_m[0]    = {8'b0, bcd_a};
  assign bcd_m[1]    = {12'b0, bcd_b};
  assign bcd_m[2]    = bcd_c;
  assign en_m[0]     = {2'b0, en_a};
  assign en_m[1]     = {3'b0, en_b};
  assign en_m[2]     = en_c;
  assign dep_m[0]    = dep_a;
  assign dep_m[1]    = dep_b;
  assign dep_m[2]    = dep_c;
  assign valide_m[0] = valide_a;
  assign valide_m[1] = valide_b;
  assign valide_m[2] = valide_c;
  assign pret_m[0]   = pret_a;
  assign pret_m[1]   = pret_b;
  assign pret_m[2]   = pret_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [15:0] v;
    logic [19:0] bcd;
    logic [4:0]  en;
    logic        dep;
    int          lat;
  } vec_t;

  vec_t tbl [18];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full conversion: accept on the next edge, then wait (bounded) for valide.
  // lat stays 0 if valide never arrives, which the caller flags as a failure.
  task automatic applyStimulus(input int sel, input logic [15:0] v,
                               output logic [19:0] b, output logic [4:0] e,
                               output logic d, output int lat,
                               output int pret_bad, output logic extra);
    @(negedge clk);
    val_in[sel] = v;
    dem[sel]    = 1'b1;
    @(posedge clk);
    #1;
    dem[sel]    = 1'b0;
    val_in[sel] = ~v;
    lat      = 0;
    pret_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (valide_m[sel]) begin
        lat = i;
        break;
      end
      if (pret_m[sel]) pret_bad++;
    end
    b = bcd_m[sel];
    e = en_m[sel];
    d = dep_m[sel];
    @(posedge clk);
    #1;
    extra = valide_m[sel];
  endtask

  initial begin
    logic [19:0] b;
    logic [4:0]  e;
    logic        d;
    int          lat;
    int          pret_bad;
    logic        extra;
    int          stray;

    n_cmp  = 0;
    n_fail = 0;

    tbl[0]  = '{0, 16'd0,     20'h00000, 5'b00001, 1'b0, 8};
    tbl[1]  = '{0, 16'd45,    20'h00045, 5'b00011, 1'b0, 8};
    tbl[2]  = '{0, 16'd127,   20'h00127, 5'b00111, 1'b0, 8};
    tbl[3]  = '{0, 16'd9,     20'h00009, 5'b00001, 1'b0, 8};
    tbl[4]  = '{0, 16'd10,    20'h00010, 5'b00011, 1'b0, 8};
    tbl[5]  = '{0, 16'd100,   20'h00100, 5'b00111, 1'b0, 8};
    tbl[6]  = '{0, 16'd88,    20'h00088, 5'b00011, 1'b0, 8};
    tbl[7]  = '{1, 16'd100,   20'h00099, 5'b00011, 1'b1, 8};
    tbl[8]  = '{1, 16'd7,     20'h00007, 5'b00001, 1'b0, 8};
    tbl[9]  = '{1, 16'd99,    20'h00099, 5'b00011, 1'b0, 8};
    tbl[10] = '{1, 16'd127,   20'h00099, 5'b00011, 1'b1, 8};
    tbl[11] = '{1, 16'd10,    20'h00010, 5'b00011, 1'b0, 8};
    tbl[12] = '{2, 16'd65535, 20'h65535, 5'b11111, 1'b0, 17};
    tbl[13] = '{2, 16'd0,     20'h00000, 5'b00001, 1'b0, 17};
    tbl[14] = '{2, 16'd1000,  20'h01000, 5'b01111, 1'b0, 17};
    tbl[15] = '{2, 16'd40000, 20'h40000, 5'b11111, 1'b0, 17};
    tbl[16] = '{2, 16'd9,     20'h00009, 5'b00001, 1'b0, 17};
    tbl[17] = '{2, 16'd12345, 20'h12345, 5'b11111, 1'b0, 17};

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      dem[s]    = 1'b0;
      val_in[s] = 16'd0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("rst_bcd%0d", s), 32'(bcd_m[s]), 32'h0);
      checkOutput($sformatf("rst_en%0d", s), 32'(en_m[s]), 32'h1);
      checkOutput($sformatf("rst_dep%0d", s), 32'(dep_m[s]), 32'h0);
      checkOutput($sformatf("rst_valide%0d", s), 32'(valide_m[s]), 32'h0);
      checkOutput($sformatf("rst_pret%0d", s), 32'(pret_m[s]), 32'h1);
    end
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].sel, tbl[i].v, b, e, d, lat, pret_bad, extra);
      checkOutput($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      checkOutput($sformatf("v%0d_bcd", i), 32'(b), 32'(tbl[i].bcd));
      checkOutput($sformatf("v%0d_en", i), 32'(e), 32'(tbl[i].en));
      checkOutput($sformatf("v%0d_dep", i), 32'(d), 32'(tbl[i].dep));
      checkOutput($sformatf("v%0d_pret_busy", i), 32'(pret_bad), 32'h0);
      checkOutput($sformatf("v%0d_pulse_len", i), 32'(extra), 32'h0);
      checkOutput($sformatf("v%0d_hold_bcd", i), 32'(bcd_m[tbl[i].sel]), 32'(tbl[i].bcd));
    end

    // Back-to-back with demarrer held high; valeur toggled mid-conversion
    @(negedge clk);
    val_in[0] = 16'd9;
    dem[0]    = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("b2b_valide_c%0d", c), 32'(valide_a),
                  32'((c == 8) || (c == 17) || (c == 26)));
      if (c == 8) begin
        checkOutput("b2b_bcd_9", 32'(bcd_a), 32'h009);
        checkOutput("b2b_en_9", 32'(en_a), 32'b001);
      end
      if (c == 17) begin
        checkOutput("b2b_bcd_10", 32'(bcd_a), 32'h010);
        checkOutput("b2b_en_10", 32'(en_a), 32'b011);
      end
      if (c == 26) begin
        checkOutput("b2b_bcd_99", 32'(bcd_a), 32'h099);
        checkOutput("b2b_en_99", 32'(en_a), 32'b011);
      end
      if (c == 3)  val_in[0] = 16'd10;
      if (c == 12) val_in[0] = 16'd99;
      if (c == 20) begin
        val_in[0] = 16'd7;
        dem[0]    = 1'b0;
      end
    end

    // Reset asserted at step 4 of converting 88
    @(negedge clk);
    val_in[0] = 16'd88;
    dem[0]    = 1'b1;
    @(posedge clk);
    #1;
    dem[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_bcd", 32'(bcd_a), 32'h000);
    checkOutput("midrst_en", 32'(en_a), 32'b001);
    checkOutput("midrst_dep", 32'(dep_a), 32'h0);
    checkOutput("midrst_valide", 32'(valide_a), 32'h0);
    checkOutput("midrst_pret", 32'(pret_a), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (valide_a) stray++;
    end
    checkOutput("midrst_no_valide", 32'(stray), 32'h0);
    checkOutput("midrst_pret_after", 32'(pret_a), 32'h1);
    applyStimulus(0, 16'd88, b, e, d, lat, pret_bad, extra);
    checkOutput("after_rst_lat", 32'(lat), 32'd8);
    checkOutput("after_rst_bcd", 32'(b), 32'h088);
    checkOutput("after_rst_en", 32'(e), 32'b011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
